layer_0_window_sequencer: RTL
=============================

Name: layer_0_window_sequencer

Overview:
- Sits directly downstream of the network manager; consumes its `layer_0_en` and produces the `layer_0_calc_fin` pulse it counts.
- For each input image, walks every convolution window position for every layer-0 kernel and issues them to the PE array over a valid/ready handshake.
- Counts returned PE results and signals image completion only when all results are back.

Parameters:
- IMAGE_SIZE, 32, input image edge length in pixels (square image).
- KERNEL_SIZE, 5, convolution kernel edge length; must be ≤ IMAGE_SIZE.
- KERNEL_NUM, 6, number of layer-0 kernels (output feature maps).
- Derived localparams:
  - OUT_SIZE = IMAGE_SIZE-KERNEL_SIZE+1
  - TOTAL = OUT_SIZE*OUT_SIZE*KERNEL_NUM
  - POS_W = logb2(OUT_SIZE), KER_W = logb2(KERNEL_NUM), ADDR_W = logb2(IMAGE_SIZE*IMAGE_SIZE), CNT_W = logb2(TOTAL+1), each minimum 1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, synchronous reset, active-high (1 = reset).
- layer_0_en, input, 1, image-processing enable from the network manager.
- win_valid, output, 1, window descriptor valid.
- win_ready, input, 1, PE array accepts the descriptor.
- win_row, output, POS_W, output-map row of the current window.
- win_col, output, POS_W, output-map column of the current window.
- win_addr, output, ADDR_W, image address of the window's top-left pixel: win_row*IMAGE_SIZE+win_col.
- kernel_idx, output, KER_W, kernel for the current window.
- result_valid, input, 1, one PE result returned this cycle.
- layer_0_calc_fin, output, 1, one-cycle pulse: current image complete.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; row, col, kernel and result counters 0.
- States:
  - IDLE: wait for layer_0_en=1, then go to ISSUE next cycle with counters cleared.
  - ISSUE: win_valid=1. Descriptor outputs are registered and must stay stable until the cycle win_valid&win_ready is seen.
    - Each handshake advances col first; col wraps OUT_SIZE-1→0 and increments row.
    - row wraps OUT_SIZE-1→0 and increments kernel_idx.
    - The handshake with kernel_idx=KERNEL_NUM-1, row=col=OUT_SIZE-1 is the last one; go to DRAIN, win_valid=0 next cycle.
    - Throughput: one descriptor per cycle when win_ready is held high. There is no bubble between descriptors.
  - DRAIN: wait until result_count==TOTAL, then go to FIN.
  - FIN: layer_0_calc_fin=1 for exactly this cycle, then go to IDLE.
    - The next image starts only if layer_0_en is 1 while in IDLE. The manager drops enable after the last image, so the sequencer stops there.
- result_valid counting:
  - Counted in ISSUE, DRAIN and FIN, whenever it is 1.
  - Ignored in IDLE.
  - result_count saturates at TOTAL.
  - If the count reaches TOTAL in the same cycle as the last handshake, FIN follows DRAIN after one cycle. FIN is never skipped.
- Abort: layer_0_en=0 in ISSUE, DRAIN or FIN forces IDLE next cycle.
  - win_valid drops and counters clear.
  - No calc_fin pulse is generated (except that a pulse already being driven in FIN completes).
- Reset mid-operation: immediate return to reset values on the next edge, regardless of state.
- Descriptor arithmetic: win_addr is computed from the next row/col values and registered together with them. All values are unsigned with no truncation: ADDR_W covers IMAGE_SIZE²-1.

Optional Feature:
- Macro: LAYER_0_SEQ_ERR_CHECK_EN.
- When defined, adds output port seq_err (1 bit, reset 0, sticky until reset). seq_err sets when either:
  - result_valid=1 while in IDLE, or
  - result_valid=1 while result_count==TOTAL.
- When undefined, the port and its logic are absent, and such results are silently ignored or saturated as described above.

Test Plan:
- Basic sequence (IMAGE_SIZE=6, KERNEL_SIZE=3, KERNEL_NUM=2, win_ready=1, each result returned 3 cycles after its handshake): expect 32 descriptors.
  - Order: (k0,r0,c0) … (k0,r3,c3), (k1,r0,c0) …
  - win_addr sequence starts 0,1,2,3,6,7…
  - Exactly one calc_fin pulse, 3 cycles after the last handshake plus DRAIN→FIN.
- Backpressure: win_ready toggles 1,0,0,1 repeatedly → descriptor outputs hold while win_ready=0; no skipped or duplicated window; 32 handshakes total.
- Back-to-back images: layer_0_en held 1 across two images → second image's first win_valid occurs 2 cycles after the calc_fin pulse (FIN→IDLE→ISSUE); two calc_fin pulses total.
- Abort: drop layer_0_en after 10 handshakes → win_valid=0 and busy=0 next cycle; no calc_fin. Re-enable → sequence restarts at (k0,r0,c0).
- Early results: all 32 results arrive by the last handshake → DRAIN lasts 1 cycle, then FIN; calc_fin pulses once.
- Error check (LAYER_0_SEQ_ERR_CHECK_EN defined): pulse result_valid in IDLE → seq_err=1 next cycle and stays 1 until rst_n=1.

Source files
------------

// File: rtl/layer_0_window_sequencer.sv
// Layer-0 convolution window sequencer.
// For each image, issues every (kernel, row, col) window descriptor to the PE array over a
// valid/ready handshake, counts returned PE results and pulses layer_0_calc_fin once all
// results are back. Optional sticky seq_err output is enabled by defining
// LAYER_0_SEQ_ERR_CHECK_EN.
// Note: rst_n is a synchronous, active-HIGH reset despite its name.
module layer_0_window_sequencer #(
  parameter int unsigned IMAGE_SIZE  = 32,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned KERNEL_NUM  = 6,
  localparam int unsigned OUT_SIZE   = IMAGE_SIZE - KERNEL_SIZE + 1,
  localparam int unsigned TOTAL      = OUT_SIZE * OUT_SIZE * KERNEL_NUM,
  localparam int unsigned POS_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1,
  localparam int unsigned KER_W      = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1,
  localparam int unsigned ADDR_W     = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE * IMAGE_SIZE) : 1,
  localparam int unsigned CNT_W      = $clog2(TOTAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              layer_0_en,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [POS_W-1:0]  win_row,
  output logic [POS_W-1:0]  win_col,
  output logic [ADDR_W-1:0] win_addr,
  output logic [KER_W-1:0]  kernel_idx,
  input  logic              result_valid,
  output logic              layer_0_calc_fin,
  output logic              busy
`ifdef LAYER_0_SEQ_ERR_CHECK_EN
  ,
  output logic              seq_err
`endif
);

  localparam logic [POS_W-1:0]  PosLast  = POS_W'(OUT_SIZE - 1);
  localparam logic [KER_W-1:0]  KerLast  = KER_W'(KERNEL_NUM - 1);
  localparam logic [CNT_W-1:0]  CntTotal = CNT_W'(TOTAL);
  localparam logic [ADDR_W-1:0] ImgSize  = ADDR_W'(IMAGE_SIZE);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   result_cnt_q;

  logic               hs;
  logic               last_hs;
  logic [POS_W-1:0]   row_nxt;
  logic [POS_W-1:0]   col_nxt;
  logic [KER_W-1:0]   ker_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // Next window position (col fastest, then row, then kernel) and its top-left pixel address.
  always_comb begin
    hs      = win_valid & win_ready;
    last_hs = hs & (win_col == PosLast) & (win_row == PosLast) & (kernel_idx == KerLast);
    row_nxt = win_row;
    col_nxt = win_col;
    ker_nxt = kernel_idx;
    if (win_col == PosLast) begin
      col_nxt = '0;
      if (win_row == PosLast) begin
        row_nxt = '0;
        ker_nxt = kernel_idx + KER_W'(1);
      end else begin
        row_nxt = win_row + POS_W'(1);
      end
    end else begin
      col_nxt = win_col + POS_W'(1);
    end
    // After the final window the descriptor returns to the origin.
    if (last_hs) begin
      row_nxt = '0;
      col_nxt = '0;
      ker_nxt = '0;
    end
    addr_nxt = ADDR_W'(row_nxt) * ImgSize + ADDR_W'(col_nxt);
    cnt_nxt  = result_cnt_q;
    if (result_valid && (result_cnt_q != CntTotal)) begin
      cnt_nxt = result_cnt_q + CNT_W'(1);
    end
  end

  // Sequencer FSM with registered descriptor, status and completion outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q          <= StIdle;
      result_cnt_q     <= '0;
      win_valid        <= 1'b0;
      win_row          <= '0;
      win_col          <= '0;
      win_addr         <= '0;
      kernel_idx       <= '0;
      layer_0_calc_fin <= 1'b0;
      busy             <= 1'b0;
    end else begin
      layer_0_calc_fin <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (layer_0_en) begin
            state_q      <= StIssue;
            win_valid    <= 1'b1;
            busy         <= 1'b1;
            result_cnt_q <= '0;
            win_row      <= '0;
            win_col      <= '0;
            win_addr     <= '0;
            kernel_idx   <= '0;
          end
        end
        StIssue: begin
          if (!layer_0_en) begin
            state_q      <= StIdle;
            win_valid    <= 1'b0;
            busy         <= 1'b0;
            result_cnt_q <= '0;
            win_row      <= '0;
            win_col      <= '0;
            win_addr     <= '0;
            kernel_idx   <= '0;
          end else begin
            result_cnt_q <= cnt_nxt;
            if (hs) begin
              win_row    <= row_nxt;
              win_col    <= col_nxt;
              win_addr   <= addr_nxt;
              kernel_idx <= ker_nxt;
              if (last_hs) begin
                state_q   <= StDrain;
                win_valid <= 1'b0;
              end
            end
          end
        end
        StDrain: begin
          if (!layer_0_en) begin
            state_q      <= StIdle;
            busy         <= 1'b0;
            result_cnt_q <= '0;
          end else begin
            result_cnt_q <= cnt_nxt;
            // Uses the registered count, so FIN always gets its own cycle after DRAIN.
            if (result_cnt_q == CntTotal) begin
              state_q          <= StFin;
              layer_0_calc_fin <= 1'b1;
            end
          end
        end
        StFin: begin
          state_q      <= StIdle;
          busy         <= 1'b0;
          result_cnt_q <= '0;
        end
        default: begin
          state_q   <= StIdle;
          win_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAYER_0_SEQ_ERR_CHECK_EN
  // Sticky flag for results that arrive when none can be outstanding.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      seq_err <= 1'b0;
    end else if (result_valid && ((state_q == StIdle) || (result_cnt_q == CntTotal))) begin
      seq_err <= 1'b1;
    end
  end
`endif

endmodule
